fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-side pointer and flag generator for the async FIFO. Sits directly upstream of the FIFO memory and runs entirely in the write clock domain.
- Produces the binary write pointer that addresses the memory, the Gray write pointer exported to the read domain, and the full flag that gates memory writes.
- Also provides almost-full, fill level and a sticky overflow indicator. Synchronizes the read domain's Gray read pointer internally.

Parameters:
- P_DEPTH, 8, FIFO entries; power of two, >= 4.
- P_PTR_W, 4, pointer width = log2(P_DEPTH) + 1; MSB is the wrap bit.
- P_SYNC_STAGES, 2, flops in the read-pointer synchronizer; >= 2.
- P_AFULL_TH, 6, fill level at which o_almost_full asserts; 1..P_DEPTH.

Ports:
- wclk  in  1  write clock; the block's only clock.
- wrst_n  in  1  asynchronous, active-low reset.
- w_en  in  1  write request. Accepted only when o_full = 0.
- g_rptr_async  in  P_PTR_W  Gray read pointer from the read domain; asynchronous to wclk.
- i_ovf_clr  in  1  clears o_overflow.
- b_wptr  out  P_PTR_W  binary write pointer; goes to the memory write address.
- g_wptr  out  P_PTR_W  Gray write pointer; goes to the read-domain synchronizer.
- o_full  out  1  FIFO full; also drives the memory's full input.
- o_almost_full  out  1  fill level >= P_AFULL_TH.
- o_wlevel  out  P_PTR_W  write-side fill level, 0..P_DEPTH.
- o_overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset: wrst_n low clears every register immediately, with no clock edge needed.
  - b_wptr=0, g_wptr=0, o_full=0, o_almost_full=0, o_wlevel=0, o_overflow=0.
  - All synchronizer flops reset to 0.
- Accept: wr_ok = w_en & ~o_full.
  - b_next = b_wptr + wr_ok, modulo 2^P_PTR_W. 1111 wraps to 0000.
  - g_next = b_next ^ (b_next >> 1).
  - b_wptr and g_wptr are registered from b_next and g_next. g_wptr is a flop output with no combinational path, and changes by at most one bit per cycle.
- Read-pointer sync: g_rptr_async passes through a P_SYNC_STAGES flop chain to give g_rptr_s. No logic sits between the chain stages.
- Full:
  - o_full <= (g_next == {~g_rptr_s[P_PTR_W-1:P_PTR_W-2], g_rptr_s[P_PTR_W-3:0]}).
  - Full asserts on the same edge that accepts the P_DEPTH-th outstanding write.
  - Full deasserts no earlier than P_SYNC_STAGES+1 wclk edges after g_rptr_async changes. This delay is pessimistic and therefore safe.
- Level and almost-full:
  - r_bin = gray2bin(g_rptr_s).
  - o_wlevel <= b_next - r_bin, modulo 2^P_PTR_W. Never exceeds P_DEPTH; it may over-report because of sync lag.
  - o_almost_full <= (b_next - r_bin) >= P_AFULL_TH. Registered, same timing as o_full.
- Overflow:
  - A w_en while o_full=1 sets o_overflow on that edge. That write is dropped and b_wptr holds.
  - i_ovf_clr clears o_overflow on the next edge.
  - Simultaneous set and clear: set wins.
- Boundaries:
  - Write on the last free slot sets full. A write while full has no effect except overflow.
  - Pointer wrap produces no false full or false empty: the MSB and MSB-1 inversion handles it.
  - w_en held high across full deassertion: the write is accepted on the first edge where o_full=0.
  - Reset mid-burst: state returns to empty, and writes resume from pointer 0 after wrst_n rises.
- Bad values: a non-Gray g_rptr_async is undefined input. No checking is required.

Decomposition:
- Shared package holds:
  - bin2gray and gray2bin functions.
  - Pointer-width calculation function.
  - Default P_DEPTH and P_SYNC_STAGES constants.
  - The same content is reused by the read-side pointer block.
- One sub-module: sync_nff (parameterized width and stage count, async active-low reset). Instantiated for g_rptr_async, and reused later on the read side.

Test Plan:
All scenarios use P_DEPTH=8, P_PTR_W=4, P_SYNC_STAGES=2, P_AFULL_TH=6.
- Reset: assert wrst_n=0 mid-cycle with no wclk edge -> all outputs 0 immediately. Release, then idle 3 cycles -> outputs remain 0.
- Fill: g_rptr_async=0, 8 consecutive w_en -> after 6th write o_almost_full=1 and o_wlevel=6. After 8th: b_wptr=1000, g_wptr=1100, o_full=1, o_wlevel=8.
- Overflow: while full, pulse w_en 1 cycle -> b_wptr stays 1000, o_overflow=1 and stays 1. i_ovf_clr with no w_en -> 0 next edge. i_ovf_clr together with w_en while full -> stays 1.
- Drain: from full, set g_rptr_async=0011 (gray 2) -> o_full=0, o_wlevel=6, o_almost_full=1 exactly 3 edges later. Set to 0010 (gray 3) -> o_wlevel=5, o_almost_full=0.
- Wrap: 20 writes with g_rptr_async tracking gray(b_wptr-2) -> b_wptr goes 1111 then 0000, g_wptr goes 1000 then 0000. o_full never asserts and o_wlevel stays <= 2 throughout.
- Reset mid-burst: w_en held high, wrst_n low after 5 writes -> outputs 0 asynchronously. After release, the first write gives b_wptr=0001 and g_wptr=0001.

Source files
------------

// File: rtl/fifo_wptr_full_pkg.sv
// Shared pointer helpers for the async FIFO.
// Used by both the write-side and read-side pointer blocks.
package fifo_wptr_full_pkg;

  localparam int FWF_DEPTH_DEF = 8;
  localparam int FWF_SYNC_DEF  = 2;

  typedef logic [31:0] ptr_max_t;

  // Pointer width: one address bit per entry doubling plus the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits beyond the real width are zero, so the fold is exact.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side FIFO pointer/flag bundle.
// slave = pointer block, master = write client.
interface fifo_wptr_full_if #(
  parameter int P_PTR_W = 4
);

  logic               w_en;
  logic [P_PTR_W-1:0] g_rptr_async;
  logic               i_ovf_clr;
  logic [P_PTR_W-1:0] b_wptr;
  logic [P_PTR_W-1:0] g_wptr;
  logic               o_full;
  logic               o_almost_full;
  logic [P_PTR_W-1:0] o_wlevel;
  logic               o_overflow;

  modport slave (
    input  w_en,
    input  g_rptr_async,
    input  i_ovf_clr,
    output b_wptr,
    output g_wptr,
    output o_full,
    output o_almost_full,
    output o_wlevel,
    output o_overflow
  );

  modport master (
    output w_en,
    output g_rptr_async,
    output i_ovf_clr,
    input  b_wptr,
    input  g_wptr,
    input  o_full,
    input  o_almost_full,
    input  o_wlevel,
    input  o_overflow
  );

endinterface

// File: rtl/fifo_wptr_full_sync_nff.sv
// N-flop multi-bit synchronizer for Gray-coded pointers.
// Plain flop chain, nothing between stages.
module sync_nff #(
  parameter int P_W      = 4,
  parameter int P_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [P_W-1:0] d,
  output logic [P_W-1:0] q
);

  logic [P_W-1:0] stg [P_STAGES];

  // Shift the async input through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < P_STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[P_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full, level and overflow logic.
// Runs entirely in the write clock domain.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int P_DEPTH       = FWF_DEPTH_DEF,
  parameter int P_PTR_W       = ptr_w(P_DEPTH),
  parameter int P_SYNC_STAGES = FWF_SYNC_DEF,
  parameter int P_AFULL_TH    = 6
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wptr_full_if.slave   wif
);

  localparam logic [P_PTR_W-1:0] AF_TH = P_PTR_W'(P_AFULL_TH);

  logic [P_PTR_W-1:0] g_rptr_s;
  logic [P_PTR_W-1:0] r_bin;
  logic [P_PTR_W-1:0] b_q;
  logic [P_PTR_W-1:0] g_q;
  logic [P_PTR_W-1:0] b_next;
  logic [P_PTR_W-1:0] g_next;
  logic [P_PTR_W-1:0] g_full;
  logic [P_PTR_W-1:0] lvl_next;
  logic               full_q;
  logic               afull_q;
  logic [P_PTR_W-1:0] lvl_q;
  logic               ovf_q;
  logic               wr_ok;

  sync_nff #(
    .P_W      (P_PTR_W),
    .P_STAGES (P_SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (wif.g_rptr_async),
    .q     (g_rptr_s)
  );

  assign wr_ok  = wif.w_en & ~full_q;
  assign b_next = b_q + {{(P_PTR_W-1){1'b0}}, wr_ok};
  assign g_next = P_PTR_W'(bin2gray(32'(b_next)));
  assign r_bin  = P_PTR_W'(gray2bin(32'(g_rptr_s)));

  // Full when writer is one lap ahead: top two Gray bits inverted.
  assign g_full = {~g_rptr_s[P_PTR_W-1:P_PTR_W-2],
                   g_rptr_s[P_PTR_W-3:0]};

  assign lvl_next = b_next - r_bin;

  // Pointers and flags, all registered from next-state values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_q     <= '0;
      g_q     <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      lvl_q   <= '0;
    end else begin
      b_q     <= b_next;
      g_q     <= g_next;
      full_q  <= (g_next == g_full);
      afull_q <= (lvl_next >= AF_TH);
      lvl_q   <= lvl_next;
    end
  end

  // Sticky overflow; a new overflow beats a clear in the same cycle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_q <= 1'b0;
    end else if (wif.w_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (wif.i_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wif.b_wptr        = b_q;
  assign wif.g_wptr        = g_q;
  assign wif.o_full        = full_q;
  assign wif.o_almost_full = afull_q;
  assign wif.o_wlevel      = lvl_q;
  assign wif.o_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for the FIFO write-side pointer block.
// Inputs driven and outputs sampled on the falling edge.
module tb_fifo_wptr_full;

  logic wclk;
  logic wrst_n;
  int   errors;
  int   checks;
  logic [3:0] bm;

  fifo_wptr_full_if #(.P_PTR_W(4)) wif ();

  fifo_wptr_full #(
    .P_DEPTH       (8),
    .P_PTR_W       (4),
    .P_SYNC_STAGES (2),
    .P_AFULL_TH    (6)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wif    (wif.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    g[2] = b[3] ^ b[2];
    g[1] = b[2] ^ b[1];
    g[0] = b[1] ^ b[0];
    return g;
  endfunction

  task automatic step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic check_zero(input string tag);
    logic [17:0] got;
    got = {wif.b_wptr, wif.g_wptr, wif.o_full,
           wif.o_almost_full, wif.o_wlevel, wif.o_overflow};
    checks++;
    if (got !== 18'h0) begin
      errors++;
      $display("FAIL %s: outputs=%h want 0", tag, got);
    end
  endtask

  task automatic test_reset();
    wif.w_en = 0;
    wif.i_ovf_clr = 0;
    wif.g_rptr_async = '0;
    wrst_n = 1;
    @(negedge wclk);
    @(negedge wclk);
    #2 wrst_n = 0;
    #1 check_zero("reset_async");
    @(negedge wclk);
    wrst_n = 1;
    repeat (3) step();
    check_zero("reset_idle");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wif.w_en = 1;
      step();
      checks++;
      if (wif.o_wlevel !== 4'(i)) begin
        errors++;
        $display("FAIL fill_level%0d: got %0d want %0d",
                 i, wif.o_wlevel, i);
      end
      checks++;
      if (wif.o_almost_full !== (i >= 6)) begin
        errors++;
        $display("FAIL fill_afull%0d: got %b want %b",
                 i, wif.o_almost_full, (i >= 6));
      end
      checks++;
      if (wif.o_full !== (i == 8)) begin
        errors++;
        $display("FAIL fill_full%0d: got %b want %b",
                 i, wif.o_full, (i == 8));
      end
    end
    wif.w_en = 0;
    checks++;
    if (wif.b_wptr !== 4'b1000 || wif.g_wptr !== 4'b1100) begin
      errors++;
      $display("FAIL fill_ptr: got b=%b g=%b want b=1000 g=1100",
               wif.b_wptr, wif.g_wptr);
    end
  endtask

  task automatic test_overflow();
    wif.w_en = 1;
    step();
    wif.w_en = 0;
    checks++;
    if (wif.b_wptr !== 4'b1000 || wif.o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got b=%b ovf=%b want b=1000 ovf=1",
               wif.b_wptr, wif.o_overflow);
    end
    step();
    checks++;
    if (wif.o_overflow !== 1'b1 || wif.o_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b full=%b want 1 1",
               wif.o_overflow, wif.o_full);
    end
    wif.i_ovf_clr = 1;
    step();
    checks++;
    if (wif.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", wif.o_overflow);
    end
    wif.w_en = 1;
    step();
    wif.w_en = 0;
    checks++;
    if (wif.o_overflow !== 1'b1 || wif.b_wptr !== 4'b1000) begin
      errors++;
      $display("FAIL ovf_set_wins: got ovf=%b b=%b want 1 1000",
               wif.o_overflow, wif.b_wptr);
    end
    step();
    wif.i_ovf_clr = 0;
    checks++;
    if (wif.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr2: got %b want 0", wif.o_overflow);
    end
  endtask

  task automatic test_drain();
    wif.g_rptr_async = 4'b0011;
    step();
    step();
    checks++;
    if (wif.o_full !== 1'b1) begin
      errors++;
      $display("FAIL drain_early: full=%b want 1", wif.o_full);
    end
    step();
    checks++;
    if (wif.o_full !== 1'b0 || wif.o_wlevel !== 4'd6 ||
        wif.o_almost_full !== 1'b1) begin
      errors++;
      $display("FAIL drain_g2: full=%b lvl=%0d af=%b want 0 6 1",
               wif.o_full, wif.o_wlevel, wif.o_almost_full);
    end
    wif.g_rptr_async = 4'b0010;
    repeat (3) step();
    checks++;
    if (wif.o_wlevel !== 4'd5 || wif.o_almost_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_g3: lvl=%0d af=%b want 5 0",
               wif.o_wlevel, wif.o_almost_full);
    end
  endtask

  task automatic test_wrap();
    bm = 4'd8;
    for (int i = 0; i < 20; i++) begin
      wif.g_rptr_async = gray4(bm - 4'd1);
      for (int s = 0; s < 3; s++) begin
        step();
        checks++;
        if (wif.o_full !== 1'b0) begin
          errors++;
          $display("FAIL wrap_full_idle%0d: got %b want 0",
                   i, wif.o_full);
        end
      end
      wif.w_en = 1;
      step();
      wif.w_en = 0;
      bm = bm + 4'd1;
      checks++;
      if (wif.b_wptr !== bm || wif.g_wptr !== gray4(bm)) begin
        errors++;
        $display("FAIL wrap_ptr%0d: got b=%b g=%b want b=%b g=%b",
                 i, wif.b_wptr, wif.g_wptr, bm, gray4(bm));
      end
      checks++;
      if (wif.o_full !== 1'b0 || wif.o_wlevel !== 4'd2) begin
        errors++;
        $display("FAIL wrap_lvl%0d: full=%b lvl=%0d want 0 2",
                 i, wif.o_full, wif.o_wlevel);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    wif.w_en = 1;
    repeat (5) step();
    checks++;
    if (wif.b_wptr !== 4'b0001) begin
      errors++;
      $display("FAIL burst_ptr: got %b want 0001", wif.b_wptr);
    end
    #2 wrst_n = 0;
    #1 check_zero("burst_reset");
    wif.g_rptr_async = '0;
    @(negedge wclk);
    check_zero("burst_hold");
    wrst_n = 1;
    step();
    wif.w_en = 0;
    checks++;
    if (wif.b_wptr !== 4'b0001 || wif.g_wptr !== 4'b0001 ||
        wif.o_wlevel !== 4'd1) begin
      errors++;
      $display("FAIL burst_resume: b=%b g=%b lvl=%0d want 0001 0001 1",
               wif.b_wptr, wif.g_wptr, wif.o_wlevel);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
